// File: rtl/pipeline_latealu_pkg.sv
// Shared LateALU definitions. The ALU stage imports the op codes from here
// so that both stages decode requests the same way.
package pipeline_latealu_pkg;
  localparam logic [5:0] LATEALU_OP_MULT  = 6'b000100;
  localparam logic [5:0] LATEALU_OP_MTHI  = 6'b000101;
  localparam logic [5:0] LATEALU_OP_MTLO  = 6'b000110;
  localparam logic [5:0] LATEALU_OP_MULTU = 6'b000111;

  typedef enum logic [1:0] {IDLE, MUL, FIXUP} state_t;
endpackage

// File: rtl/pipeline_latealu_if.sv
// Request/result bus between the ALU stage (master) and the LateALU (slave).
interface pipeline_latealu_if;
  logic        latealu_enable;
  logic [5:0]  latealu_op;
  logic [31:0] latealu_a0;
  logic [31:0] latealu_a1;
  logic [31:0] latealu_mult_hi;
  logic [31:0] latealu_mult_lo;
  logic        busy;
  logic        req_dropped;
  logic        bad_op;

  modport master (
    output latealu_enable, latealu_op, latealu_a0, latealu_a1,
    input  latealu_mult_hi, latealu_mult_lo, busy, req_dropped, bad_op
  );
  modport slave (
    input  latealu_enable, latealu_op, latealu_a0, latealu_a1,
    output latealu_mult_hi, latealu_mult_lo, busy, req_dropped, bad_op
  );
endinterface

// File: rtl/pipeline_latealu_mul_iter.sv
// Unsigned 32x32 shift-add multiplier retiring RADIX_BITS multiplier bits
// per cycle. done is high during the cycle whose edge performs the last step.
module latealu_mul_iter #(
  parameter int RADIX_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic [63:0] prod,
  output logic        done
);
  localparam int STEPS = 32 / RADIX_BITS;
  localparam int CW    = $clog2(STEPS);

  logic [63:0]   md_q, acc_q, pp;
  logic [31:0]   mr_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;

  always_comb begin
    pp = '0;
    for (int i = 0; i < RADIX_BITS; i++)
      if (mr_q[i]) pp = pp + (md_q << i);
  end

  assign done = run_q && (cnt_q == CW'(STEPS - 1));
  assign prod = acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      md_q  <= '0;
      mr_q  <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      acc_q <= '0;
      md_q  <= {32'd0, mcand};
      mr_q  <= mplier;
    end else if (run_q) begin
      acc_q <= acc_q + pp;
      md_q  <= md_q << RADIX_BITS;
      mr_q  <= mr_q >> RADIX_BITS;
      cnt_q <= cnt_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end
endmodule

// File: rtl/pipeline_latealu.sv
// LateALU: owns HI/LO, runs mult/multu on the iterative core, applies the
// sign fixup, and flags dropped or malformed requests.
module pipeline_latealu
  import pipeline_latealu_pkg::*;
#(
  parameter int RADIX_BITS = 2
) (
  input logic               clk,
  input logic               rst,
  pipeline_latealu_if.slave bus
);
  state_t      state_q, state_d;
  logic [31:0] hi_q, lo_q, mag0, mag1;
  logic [63:0] prod, fixed;
  logic        neg_q, drop_q, bad_q;
  logic        is_signed, is_mul, known, accept, start, mul_done;

  always_comb begin
    is_signed = bus.latealu_op == LATEALU_OP_MULT;
    is_mul    = is_signed || (bus.latealu_op == LATEALU_OP_MULTU);
    known     = is_mul || (bus.latealu_op == LATEALU_OP_MTHI)
                       || (bus.latealu_op == LATEALU_OP_MTLO);
    accept    = bus.latealu_enable && (state_q == IDLE) && known;
    start     = accept && is_mul;
    // two's-complement magnitude; 0x80000000 maps to itself, exact as unsigned
    mag0 = (is_signed && bus.latealu_a0[31]) ? (~bus.latealu_a0 + 32'd1) : bus.latealu_a0;
    mag1 = (is_signed && bus.latealu_a1[31]) ? (~bus.latealu_a1 + 32'd1) : bus.latealu_a1;
    fixed = neg_q ? (~prod + 64'd1) : prod;
  end

  latealu_mul_iter #(.RADIX_BITS(RADIX_BITS)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mcand  (mag0),
    .mplier (mag1),
    .prod   (prod),
    .done   (mul_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MUL;
      MUL:     if (mul_done) state_d = FIXUP;
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      drop_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= bus.latealu_enable && (state_q != IDLE);
      bad_q   <= bus.latealu_enable && (state_q == IDLE) && !known;
      if (start) neg_q <= is_signed && (bus.latealu_a0[31] ^ bus.latealu_a1[31]);
      if (accept && bus.latealu_op == LATEALU_OP_MTHI) hi_q <= bus.latealu_a0;
      if (accept && bus.latealu_op == LATEALU_OP_MTLO) lo_q <= bus.latealu_a0;
      if (state_q == FIXUP) {hi_q, lo_q} <= fixed;
    end
  end

  assign bus.latealu_mult_hi = hi_q;
  assign bus.latealu_mult_lo = lo_q;
  assign bus.busy            = state_q != IDLE;
  assign bus.req_dropped     = drop_q;
  assign bus.bad_op          = bad_q;
endmodule

// File: tb/tb_pipeline_latealu.sv
// Scoreboard bench for pipeline_latealu at RADIX_BITS 2, 1 and 8; one DUT
// is exercised at a time while the others sit idle.
module tb_pipeline_latealu;
  import pipeline_latealu_pkg::*;

  localparam int K_NONE = -1, K_MUL = 0, K_WR = 1, K_BAD = 2, K_DROP = 3;

  typedef struct {
    int          dut;
    int          kind;
    logic [31:0] hi;
    logic [31:0] lo;
    int          blen;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_q = 1'b1;
  logic        en;
  logic [5:0]  op;
  logic [31:0] a0, a1;
  logic [2:0]  sel;
  int          cur;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] hi_v [3];
  logic [31:0] lo_v [3];
  logic        busy_v [3];
  logic        drop_v [3];
  logic        bad_v [3];

  exp_t res_q[$];
  exp_t evt_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst;

  for (genvar g = 0; g < 3; g++) begin : gd
    pipeline_latealu_if ifc ();
    assign ifc.latealu_enable = en & sel[g];
    assign ifc.latealu_op     = op;
    assign ifc.latealu_a0     = a0;
    assign ifc.latealu_a1     = a1;
    pipeline_latealu #(.RADIX_BITS(g == 0 ? 2 : (g == 1 ? 1 : 8))) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
    );
    assign hi_v[g]   = ifc.latealu_mult_hi;
    assign lo_v[g]   = ifc.latealu_mult_lo;
    assign busy_v[g] = ifc.busy;
    assign drop_v[g] = ifc.req_dropped;
    assign bad_v[g]  = ifc.bad_op;
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic bad_event(input string name, input int k);
    checks++;
    errors++;
    $display("FAIL %s dut%0d: got unexpected event expected none", name, k);
  endtask

  // Monitor: samples on the falling edge and retires expected events
  logic [31:0] phi [3];
  logic [31:0] plo [3];
  logic        pbusy [3];
  int          bcnt [3];

  initial begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      phi[k] = '0; plo[k] = '0; pbusy[k] = 1'b0; bcnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst_q) begin
          phi[k] = hi_v[k]; plo[k] = lo_v[k]; pbusy[k] = 1'b0; bcnt[k] = 0;
          continue;
        end
        if (busy_v[k]) bcnt[k]++;
        if (pbusy[k] && !busy_v[k]) begin
          if (res_q.size() == 0) bad_event("mul_result", k);
          else begin
            e = res_q.pop_front();
            if (e.dut != k || e.kind != K_MUL) bad_event("mul_result", k);
            else begin
              chk("mul_hi", k, hi_v[k], e.hi);
              chk("mul_lo", k, lo_v[k], e.lo);
              chk("busy_len", k, bcnt[k], e.blen);
            end
          end
          bcnt[k] = 0;
        end else if (!busy_v[k] && (hi_v[k] !== phi[k] || lo_v[k] !== plo[k])) begin
          if (res_q.size() == 0) bad_event("hilo_write", k);
          else begin
            e = res_q.pop_front();
            if (e.dut != k || e.kind != K_WR) bad_event("hilo_write", k);
            else begin
              chk("wr_hi", k, hi_v[k], e.hi);
              chk("wr_lo", k, lo_v[k], e.lo);
            end
          end
        end
        if (drop_v[k] || bad_v[k]) begin
          if (evt_q.size() == 0) bad_event(drop_v[k] ? "req_dropped" : "bad_op", k);
          else begin
            e = evt_q.pop_front();
            if (e.dut != k) bad_event("pulse_dut", k);
            else if (e.kind == K_DROP) chk("req_dropped", k, {31'd0, drop_v[k]}, 32'd1);
            else begin
              chk("bad_op", k, {31'd0, bad_v[k]}, 32'd1);
              chk("bad_hi", k, hi_v[k], e.hi);
              chk("bad_lo", k, lo_v[k], e.lo);
            end
          end
        end
        phi[k] = hi_v[k]; plo[k] = lo_v[k]; pbusy[k] = busy_v[k];
      end
    end
  end

  task automatic issue(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int kind, input logic [31:0] eh, input logic [31:0] el, input int bl);
    exp_t e;
    e.dut = cur; e.kind = kind; e.hi = eh; e.lo = el; e.blen = bl;
    if (kind == K_DROP || kind == K_BAD) evt_q.push_back(e);
    else if (kind != K_NONE) res_q.push_back(e);
    en = 1'b1; op = o; a0 = x; a1 = y;
    @(posedge clk); #1;
    en = 1'b0; op = 6'b000000;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_v[cur] || res_q.size() != 0 || evt_q.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL wait_idle dut%0d: got timeout expected idle with empty scoreboard", cur);
    end
    idle_cycles(1);
  endtask

  task automatic chk_reset_state();
    for (int k = 0; k < 3; k++) begin
      chk("rst_hi", k, hi_v[k], 32'd0);
      chk("rst_lo", k, lo_v[k], 32'd0);
      chk("rst_busy", k, {31'd0, busy_v[k]}, 32'd0);
      chk("rst_drop", k, {31'd0, drop_v[k]}, 32'd0);
      chk("rst_bad", k, {31'd0, bad_v[k]}, 32'd0);
    end
  endtask

  initial begin
    en = 1'b0; op = 6'b000000; a0 = '0; a1 = '0; cur = 0; sel = 3'b001;
    idle_cycles(3);
    rst = 1'b0;
    chk_reset_state();

    // RADIX_BITS = 2: busy spans 17 cycles
    issue(LATEALU_OP_MULT, 32'd3, 32'hFFFF_FFFB, K_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 17);
    wait_idle();
    issue(LATEALU_OP_MULT, 32'h8000_0000, 32'h8000_0000, K_MUL, 32'h4000_0000, 32'h0, 17);
    wait_idle();
    issue(LATEALU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, K_MUL, 32'hFFFF_FFFE, 32'h1, 17);
    wait_idle();
    issue(LATEALU_OP_MTHI, 32'h1234_5678, 32'h0, K_WR, 32'h1234_5678, 32'h1, 0);
    chk("mthi_busy", 0, {31'd0, busy_v[0]}, 32'd0);
    issue(LATEALU_OP_MTLO, 32'h9ABC_DEF0, 32'h0, K_WR, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    chk("mtlo_busy", 0, {31'd0, busy_v[0]}, 32'd0);
    wait_idle();
    // mthi while multiplying is discarded; result still lands whole
    issue(LATEALU_OP_MULT, 32'd7, 32'd6, K_MUL, 32'h0, 32'd42, 17);
    idle_cycles(4);
    issue(LATEALU_OP_MTHI, 32'h0000_DEAD, 32'h0, K_DROP, 32'h0, 32'h0, 0);
    wait_idle();
    // request landing on the FIXUP edge is also dropped
    issue(LATEALU_OP_MULT, 32'hFFFF_FFFF, 32'd5, K_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 17);
    idle_cycles(16);
    issue(LATEALU_OP_MTLO, 32'h0000_5555, 32'h0, K_DROP, 32'h0, 32'h0, 0);
    wait_idle();
    // reset mid-multiply: no partial result
    issue(LATEALU_OP_MTHI, 32'h1111_1111, 32'h0, K_WR, 32'h1111_1111, 32'hFFFF_FFFB, 0);
    issue(LATEALU_OP_MTLO, 32'h1111_1111, 32'h0, K_WR, 32'h1111_1111, 32'h1111_1111, 0);
    wait_idle();
    issue(LATEALU_OP_MULT, 32'd7, 32'd6, K_NONE, 32'h0, 32'h0, 0);
    idle_cycles(6);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    chk_reset_state();
    issue(LATEALU_OP_MULT, 32'd2, 32'd2, K_MUL, 32'h0, 32'd4, 17);
    wait_idle();
    issue(6'b000001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, K_BAD, 32'h0, 32'd4, 0);
    chk("bad_busy", 0, {31'd0, busy_v[0]}, 32'd0);
    wait_idle();

    // RADIX_BITS = 1: busy spans 33 cycles
    cur = 1; sel = 3'b010;
    issue(LATEALU_OP_MULT, 32'd3, 32'hFFFF_FFFB, K_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
    wait_idle();
    issue(LATEALU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, K_MUL, 32'hFFFF_FFFE, 32'h1, 33);
    wait_idle();
    issue(LATEALU_OP_MULT, 32'h8000_0000, 32'd1, K_MUL, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    wait_idle();

    // RADIX_BITS = 8: busy spans 5 cycles
    cur = 2; sel = 3'b100;
    issue(LATEALU_OP_MULT, 32'd3, 32'hFFFF_FFFB, K_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
    wait_idle();
    issue(LATEALU_OP_MULT, 32'h8000_0000, 32'h8000_0000, K_MUL, 32'h4000_0000, 32'h0, 5);
    wait_idle();
    issue(LATEALU_OP_MULT, 32'd7, 32'd6, K_MUL, 32'h0, 32'd42, 5);
    idle_cycles(4);
    issue(LATEALU_OP_MTHI, 32'h0000_DEAD, 32'h0, K_DROP, 32'h0, 32'h0, 0);
    wait_idle();

    chk("res_q_left", cur, res_q.size(), 32'd0);
    chk("evt_q_left", cur, evt_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_latealu.md
Name: pipeline_latealu

Overview:
- Executes LateALU requests issued by the ALU stage: iterative multiply, mthi, mtlo.
- Owns the HI/LO register pair and feeds it back to the ALU stage for mfhi/mflo.
- Multi-cycle multiplier with a busy flag; the pipeline stalls mfhi/mflo/new LateALU ops while busy is high.

Parameters:
RADIX_BITS, 2, multiplier bits retired per cycle; must divide 32 (legal 1, 2, 4, 8); MUL phase lasts 32/RADIX_BITS cycles.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
latealu_enable  input  1  request strobe, one cycle per request
latealu_op  input  6  000100 mult (signed), 000101 mthi, 000110 mtlo, 000111 multu
latealu_a0  input  32  operand 0 (rs)
latealu_a1  input  32  operand 1 (rt); ignored for mthi/mtlo
latealu_mult_hi  output  32  HI register
latealu_mult_lo  output  32  LO register
busy  output  1  multiply in flight; HI/LO not yet final
req_dropped  output  1  one-cycle pulse: enable seen while busy, request discarded
bad_op  output  1  one-cycle pulse: enable with unknown op, request ignored

Behaviour:
- Reset (rst=1 at an edge): hi=lo=0, busy=0, req_dropped=0, bad_op=0, state=IDLE. rst aborts any in-flight multiply; no partial result is written.
- States: IDLE, MUL, FIXUP.
- IDLE + enable + mthi: hi<=a0 at that edge, lo unchanged, busy stays 0. mtlo is symmetric for lo.
- IDLE + enable + mult/multu: at accept edge T, latch |a0| and |a1| (raw values for multu), neg = a0[31]^a1[31] (0 for multu), zero the 64-bit accumulator and cycle counter. Go to MUL with busy=1.
- MUL: each cycle adds the partial products of the next RADIX_BITS multiplier bits (LSB first) to the accumulator and shifts. The counter counts to 32/RADIX_BITS-1, then the state goes to FIXUP.
- FIXUP: {hi,lo} <= neg ? -acc : acc (64-bit two's complement). busy<=0, state goes to IDLE.
- Latency: busy is high for exactly 32/RADIX_BITS+1 cycles after T (17 for the default). New HI/LO values become visible in the same cycle busy falls.
- During MUL/FIXUP, HI/LO hold their pre-request values.
- Magnitude of 0x80000000 is 0x80000000 (33-bit-safe unsigned), so signed -2^31 operands are exact.
- enable while busy (any op): the request is dropped, req_dropped pulses the next cycle, and the in-flight op is unaffected. The pipeline must never do this; the pulse is a debug aid.
- enable with op not in {000100..000111}: no state change, bad_op pulses the next cycle. op=000000 with enable=0 is the idle encoding.
- FIXUP cycle plus a simultaneous enable: busy is still high, so the request is dropped. Acceptance requires state==IDLE.
- enable=0: no effect in any state.

Decomposition:
- Package pipeline_latealu_pkg: op constants LATEALU_OP_MULT/MTHI/MTLO/MULTU (6-bit) and state encoding IDLE/MUL/FIXUP. The ALU stage imports the same op constants.
- Sub-module latealu_mul_iter: unsigned 32x32 iterative shift-add core with start/done, parameterised by RADIX_BITS.
- The top level holds the HI/LO registers, the sign handling/negation, the FSM and the error pulses.

Test Plan:
- mult a0=3, a1=0xFFFFFFFB -> busy high 17 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000. Then multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles -> hi/lo updated the cycle after each, busy never asserts.
- mult 7x6 accepted, mthi 0xDEAD issued 5 cycles later -> req_dropped pulses once, final hi=0, lo=42, hi not 0xDEAD.
- mult 7x6 accepted with prior hi=lo=0x11111111, rst asserted at cycle 8 -> hi=lo=0, busy=0 next cycle. A following mult 2x2 completes with lo=4.
- enable with op=000001 -> bad_op pulse, hi/lo/busy unchanged. Repeat with RADIX_BITS=1 and 8 -> busy lengths 33 and 5, same products.
